trng_entropy_buffer: RTL and testbench

- Parametrised successor to the single-channel TRNG key path. Takes raw bits from N_CH ring-oscillator channels and optionally XOR-conditions them.
- Runs a repetition-count health test on the emitted bit stream, packs bits into KEY_W-bit keys, and buffers up to DEPTH keys in a first-word-fall-through FIFO.
- Sits between the RO sampler and the data/ctrl register files.
- Keeps a threshold interrupt plus sticky fault/overflow flags.

---
 rtl/trng_pkg.sv | 25 ++
 rtl/trng_sync_fifo.sv | 80 ++++++++
 rtl/trng_entropy_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_trng_entropy_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Shared types and default sizing for the TRNG entropy buffer.
//   trng_buf_state_e : collection FSM states (IDLE, FILL, FAIL)
//   TRNG_*           : default parameter values used by trng_entropy_buffer
//   trng_lvl_w()     : width needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package trng_pkg;

  localparam int TRNG_N_CH  = 8;
  localparam int TRNG_KEY_W = 32;
  localparam int TRNG_DEPTH = 4;
  localparam int TRNG_RCT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FAIL = 2'd2
  } trng_buf_state_e;

  function automatic int trng_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// -----------------------------------------------------------------------------
// trng_sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is visible on
// data_o whenever empty_o is low; pop_i consumes it. A push into a full FIFO
// is accepted only when a pop happens in the same cycle, otherwise the word
// is dropped (the caller detects that case from full_o).
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write data_i this cycle
//   data_i   in   WIDTH   word to write
//   pop_i    in   consume the head word (ignored while empty)
//   data_o   out  WIDTH   head word, 0 while empty
//   level_o  out  LVL_W   occupancy 0..DEPTH
//   full_o   out  occupancy == DEPTH
//   empty_o  out  occupancy == 0
// -----------------------------------------------------------------------------
module trng_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level;
  logic             pop_en;
  logic             push_en;

  assign empty_o = (level == '0);
  assign full_o  = (level == LVL_W'(DEPTH));
  assign level_o = level;

  assign pop_en  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_en = push_i & (~full_o | pop_en);

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the
  // pointers/level, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr] <= data_i;
  end

  // Gate the head with empty so key_o reads 0 out of reset and after a drain.
  assign data_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/trng_entropy_buffer.sv
// -----------------------------------------------------------------------------
// trng_entropy_buffer
// Collects ring-oscillator samples, optionally XOR-folds each sample to one
// bit, runs a repetition-count health test over the emitted bit stream, packs
// the bits LSB-first into KEY_W-bit keys and queues them in an FWFT FIFO.
//
// Ports:
//   clk_i          in   clock
//   rst_i          in   synchronous active-high reset
//   enable_i       in   run entropy collection (IDLE <-> FILL)
//   cond_en_i      in   1: fold N_CH bits to 1 per sample; 0: N_CH raw bits
//   ro_bits_i      in   N_CH  sampled RO outputs
//   ro_valid_i     in   ro_bits_i valid this cycle
//   rct_cutoff_i   in   RCT_W repetition cutoff, 0 disables the test
//   irq_thresh_i   in   LVL_W level interrupt threshold, 0 disables it
//   clr_i          in   clear sticky flags, leave FAIL
//   key_o          out  KEY_W FIFO head
//   key_ready_o    out  FIFO not empty
//   key_ack_i      in   pop the head
//   level_o        out  LVL_W FIFO occupancy
//   health_fail_o  out  sticky repetition-count failure
//   overflow_o     out  sticky dropped-key flag
//   trng_intr_o    out  registered interrupt
//
// KEY_W must be a multiple of N_CH and larger than N_CH.
// -----------------------------------------------------------------------------
module trng_entropy_buffer
  import trng_pkg::*;
#(
  parameter int N_CH  = TRNG_N_CH,
  parameter int KEY_W = TRNG_KEY_W,
  parameter int DEPTH = TRNG_DEPTH,
  parameter int RCT_W = TRNG_RCT_W,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             cond_en_i,
  input  logic [N_CH-1:0]  ro_bits_i,
  input  logic             ro_valid_i,
  input  logic [RCT_W-1:0] rct_cutoff_i,
  input  logic [LVL_W-1:0] irq_thresh_i,
  input  logic             clr_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_ready_o,
  input  logic             key_ack_i,
  output logic [LVL_W-1:0] level_o,
  output logic             health_fail_o,
  output logic             overflow_o,
  output logic             trng_intr_o
);

  // Bit counter must hold count + one raw sample before the word-done compare.
  localparam int CNT_W = $clog2(KEY_W + N_CH + 1);

  trng_buf_state_e  state;
  trng_buf_state_e  state_next;

  logic [KEY_W-1:0] shreg;
  logic [KEY_W-1:0] shreg_shifted;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_step;
  logic [CNT_W-1:0] bit_sum;
  logic             word_done;

  logic [RCT_W-1:0] rct_cnt;
  logic             rct_last;
  logic [RCT_W-1:0] rct_run;
  logic             rct_tail;
  logic             rct_trip;

  logic             fold_bit;
  logic             sample_en;
  logic             rct_hit;
  logic             accept;
  logic             leave_fill;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  // ---------------------------------------------------------------------------
  // Collection FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable_i) state_next = FILL;
      FILL: begin
        if (rct_hit)        state_next = FAIL;
        else if (!enable_i) state_next = IDLE;
      end
      FAIL:    if (clr_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sample_en  = (state == FILL) & ro_valid_i;
  assign leave_fill = (state == FILL) & (state_next != FILL);

  // ---------------------------------------------------------------------------
  // Conditioning and repetition-count test
  // ---------------------------------------------------------------------------
  assign fold_bit = ^ro_bits_i;

  // Walk the emitted bits of this sample in stream order (bit 0 first) so a
  // run that crosses samples, or sits inside one raw sample, is counted
  // exactly as a serial tester would count it. A zero count means no bit has
  // been seen since the last clear, so the next bit starts a run at 1.
  always_comb begin
    logic b;
    rct_run  = rct_cnt;
    rct_tail = rct_last;
    rct_trip = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (i == 0 || !cond_en_i) begin
        b = cond_en_i ? fold_bit : ro_bits_i[i];
        if (rct_run == '0 || b != rct_tail) rct_run = RCT_W'(1);
        else if (rct_run != '1)             rct_run = rct_run + RCT_W'(1);
        rct_tail = b;
        if (rct_cutoff_i != '0 && rct_run == rct_cutoff_i) rct_trip = 1'b1;
      end
    end
  end

  assign rct_hit = sample_en & rct_trip;
  // A failing sample is discarded entirely: no packing, no push.
  assign accept  = sample_en & ~rct_hit;

  // ---------------------------------------------------------------------------
  // Packer: bits enter at the top and shift down, so after KEY_W bits the
  // first one sits in bit 0. In raw mode ro_bits_i[0] ends up lowest.
  // ---------------------------------------------------------------------------
  assign shreg_shifted = cond_en_i ? {fold_bit, shreg[KEY_W-1:1]}
                                   : {ro_bits_i, shreg[KEY_W-1:N_CH]};
  assign bit_step  = cond_en_i ? CNT_W'(1) : CNT_W'(N_CH);
  assign bit_sum   = bit_cnt + bit_step;
  // '>=' rather than '==' so a mid-word mode change still completes a word.
  assign word_done = (bit_sum >= CNT_W'(KEY_W));

  assign fifo_push = accept & word_done;
  assign fifo_pop  = key_ack_i & key_ready_o;
  assign fifo_drop = fifo_push & fifo_full & ~fifo_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      rct_cnt  <= '0;
      rct_last <= 1'b0;
    end else begin
      if (accept) begin
        shreg    <= shreg_shifted;
        bit_cnt  <= word_done ? '0 : bit_sum;
        rct_cnt  <= rct_run;
        rct_last <= rct_tail;
      end
      // Leaving FILL (to IDLE or FAIL) abandons the partial word and the run.
      if (leave_fill) begin
        bit_cnt <= '0;
        rct_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags and interrupt; a new event beats a coincident clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      health_fail_o <= 1'b0;
      overflow_o    <= 1'b0;
      trng_intr_o   <= 1'b0;
    end else begin
      health_fail_o <= rct_hit   | (health_fail_o & ~clr_i);
      overflow_o    <= fifo_drop | (overflow_o & ~clr_i);
      trng_intr_o   <= ((irq_thresh_i != '0) && (level_o >= irq_thresh_i))
                       | health_fail_o | overflow_o;
    end
  end

  // ---------------------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------------------
  trng_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (shreg_shifted),
    .pop_i   (fifo_pop),
    .data_o  (key_o),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign key_ready_o = ~fifo_empty;

endmodule

// File: tb/tb_trng_entropy_buffer.sv
// -----------------------------------------------------------------------------
// tb_trng_entropy_buffer
// Directed bench for trng_entropy_buffer with default parameters
// (N_CH=8, KEY_W=32, DEPTH=4, RCT_W=6, LVL_W=3). Inputs change 1ns after
// the rising edge; outputs are read at the same point.
// -----------------------------------------------------------------------------
module tb_trng_entropy_buffer;
  import trng_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        cond_en_i;
  logic [7:0]  ro_bits_i;
  logic        ro_valid_i;
  logic [5:0]  rct_cutoff_i;
  logic [2:0]  irq_thresh_i;
  logic        clr_i;
  logic [31:0] key_o;
  logic        key_ready_o;
  logic        key_ack_i;
  logic [2:0]  level_o;
  logic        health_fail_o;
  logic        overflow_o;
  logic        trng_intr_o;

  int checks = 0;
  int errors = 0;

  trng_entropy_buffer dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .cond_en_i     (cond_en_i),
    .ro_bits_i     (ro_bits_i),
    .ro_valid_i    (ro_valid_i),
    .rct_cutoff_i  (rct_cutoff_i),
    .irq_thresh_i  (irq_thresh_i),
    .clr_i         (clr_i),
    .key_o         (key_o),
    .key_ready_o   (key_ready_o),
    .key_ack_i     (key_ack_i),
    .level_o       (level_o),
    .health_fail_o (health_fail_o),
    .overflow_o    (overflow_o),
    .trng_intr_o   (trng_intr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ro_bits_i  = b;
    ro_valid_i = 1'b1;
    tick();
    ro_valid_i = 1'b0;
  endtask

  // Raw mode: four samples, low byte first.
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic ack_one();
    key_ack_i = 1'b1;
    tick();
    key_ack_i = 1'b0;
  endtask

  logic [31:0] heads [4];

  initial begin
    rst_i        = 1'b1;
    enable_i     = 1'b0;
    cond_en_i    = 1'b0;
    ro_bits_i    = '0;
    ro_valid_i   = 1'b0;
    rct_cutoff_i = '0;
    irq_thresh_i = '0;
    clr_i        = 1'b0;
    key_ack_i    = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    // Reset state
    check("rst_ready", key_ready_o, 0);
    check("rst_level", level_o, 0);
    check("rst_key", key_o, 0);
    check("rst_hfail", health_fail_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_intr", trng_intr_o, 0);
    check("rst_state", dut.state, IDLE);

    // Cond mode: alternating fold 1,0,1,... -> 0x55555555
    cond_en_i = 1'b1;
    enable_i  = 1'b1;
    tick();
    check("fill_state", dut.state, FILL);
    for (int i = 0; i < 31; i++) send((i % 2 == 0) ? 8'h01 : 8'h00);
    check("cond_31_ready", key_ready_o, 0);
    send(8'h00);
    check("cond_key", key_o, 32'h5555_5555);
    check("cond_ready", key_ready_o, 1);
    check("cond_level", level_o, 1);
    ack_one();
    check("cond_ack_level", level_o, 0);

    // Raw mode: DE AD BE EF
    cond_en_i = 1'b0;
    send(8'hEF);
    send(8'hBE);
    send(8'hAD);
    check("raw_3_ready", key_ready_o, 0);
    send(8'hDE);
    check("raw_key", key_o, 32'hDEAD_BEEF);
    check("raw_level", level_o, 1);
    ack_one();

    // Level interrupt with threshold 2
    irq_thresh_i = 3'd2;
    push_word(32'h4433_2211);
    tick();
    check("irq_one_key", trng_intr_o, 0);
    push_word(32'h8877_6655);
    check("irq_two_level", level_o, 2);
    tick();
    check("irq_two_keys", trng_intr_o, 1);
    ack_one();
    check("irq_ack_head", key_o, 32'h8877_6655);
    tick();
    check("irq_after_ack", trng_intr_o, 0);
    ack_one();
    irq_thresh_i = '0;
    check("irq_drained", level_o, 0);

    // Overflow: five words into a four-deep FIFO, word 5 dropped
    for (int w = 1; w <= 5; w++) push_word({4{8'(w)}});
    check("ovf_level", level_o, 4);
    check("ovf_flag", overflow_o, 1);
    check("ovf_head", key_o, 32'h0101_0101);
    // Push word 6 while popping on the completing sample
    send(8'h06);
    send(8'h06);
    send(8'h06);
    key_ack_i = 1'b1;
    send(8'h06);
    key_ack_i = 1'b0;
    check("pp_level", level_o, 4);
    check("pp_head", key_o, 32'h0202_0202);
    check("ovf_intr", trng_intr_o, 1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("ovf_clr", overflow_o, 0);
    heads[0] = 32'h0202_0202;
    heads[1] = 32'h0303_0303;
    heads[2] = 32'h0404_0404;
    heads[3] = 32'h0606_0606;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), key_o, heads[i]);
      ack_one();
    end
    check("drain_empty", key_ready_o, 0);

    // Repetition count: cutoff 5, folded bit held at 1
    enable_i = 1'b0;
    tick();
    enable_i = 1'b1;
    tick();
    cond_en_i    = 1'b1;
    rct_cutoff_i = 6'd5;
    for (int i = 0; i < 4; i++) send(8'h01);
    check("rct_4_ok", health_fail_o, 0);
    send(8'h01);
    check("rct_fail", health_fail_o, 1);
    check("rct_state", dut.state, FAIL);
    check("rct_no_key", level_o, 0);
    tick();
    check("rct_intr", trng_intr_o, 1);
    check("rct_hold_fail", dut.state, FAIL);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check("rct_clr_flag", health_fail_o, 0);
    check("rct_clr_state", dut.state, IDLE);
    enable_i     = 1'b0;
    rct_cutoff_i = '0;
    tick();

    // Reset mid-operation: three keys queued plus a partial word
    cond_en_i = 1'b0;
    enable_i  = 1'b1;
    tick();
    push_word(32'hA1A2_A3A4);
    push_word(32'hB1B2_B3B4);
    push_word(32'hC1C2_C3C4);
    send(8'h11);
    send(8'h22);
    check("pre_rst_level", level_o, 3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_level", level_o, 0);
    check("mid_rst_ready", key_ready_o, 0);
    check("mid_rst_hfail", health_fail_o, 0);
    check("mid_rst_ovf", overflow_o, 0);
    check("mid_rst_intr", trng_intr_o, 0);
    check("mid_rst_state", dut.state, IDLE);
    tick();
    send(8'h78);
    send(8'h56);
    send(8'h34);
    check("fresh_3_ready", key_ready_o, 0);
    send(8'h12);
    check("fresh_ready", key_ready_o, 1);
    check("fresh_key", key_o, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
